// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared two-slave system bus: one registered one-hot grant.
// Define ARB_QUANTUM_EN to bound each owner's tenure to QUANTUM cycles while others wait.
module bus_arbiter_rr #(
    parameter int NUM_M   = 4,
    parameter int ID_W    = 2,
    parameter int QUANTUM = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arbState_t;

    // Reject illegal parameter sets at elaboration rather than building a broken arbiter.
    if (NUM_M < 2 || NUM_M > 8 || NUM_M > (1 << ID_W) ||
        QUANTUM < 2 || QUANTUM > (1 << CNT_W)) begin : g_badParams
        $error("bus_arbiter_rr: illegal parameter combination");
    end

    arbState_t        r_state;
    arbState_t        w_nextState;
    logic [NUM_M-1:0] r_grant;
    logic [NUM_M-1:0] w_nextGrant;
    logic [ID_W-1:0]  r_grantId;
    logic [ID_W-1:0]  w_nextGrantId;
    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  w_nextLast;
    logic [NUM_M-1:0] w_candidates;
    logic [ID_W-1:0]  w_winner;
    logic             w_found;
    logic [NUM_M-1:0] w_winnerOneHot;

`ifdef ARB_QUANTUM_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);
`endif

    // While owning, the owner is masked out so a handover never re-selects it.
    assign w_candidates = (r_state == OWN) ? (req & ~r_grant) : req;

    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(r_last) + k) % NUM_M;
            if (!w_found && w_candidates[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    assign w_winnerOneHot = {{(NUM_M-1){1'b0}}, 1'b1} << w_winner;

    // Next-state and next-grant decision; last always tracks the current owner.
    always_comb begin
        w_nextState   = r_state;
        w_nextGrant   = r_grant;
        w_nextGrantId = r_grantId;
        w_nextLast    = r_last;
`ifdef ARB_QUANTUM_EN
        w_nextCnt     = r_cnt;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nextState   = OWN;
                    w_nextGrant   = w_winnerOneHot;
                    w_nextGrantId = w_winner;
                    w_nextLast    = w_winner;
`ifdef ARB_QUANTUM_EN
                    w_nextCnt     = '0;
`endif
                end
            end
            OWN: begin
                if (req[r_grantId]) begin
`ifdef ARB_QUANTUM_EN
                    if (r_cnt == CNT_LAST) begin
                        w_nextCnt = '0;
                        if (w_found) begin
                            w_nextGrant   = w_winnerOneHot;
                            w_nextGrantId = w_winner;
                            w_nextLast    = w_winner;
                        end
                    end else if (r_cnt != '1) begin
                        w_nextCnt = r_cnt + 1'b1;
                    end
`endif
                end else if (w_found) begin
                    w_nextGrant   = w_winnerOneHot;
                    w_nextGrantId = w_winner;
                    w_nextLast    = w_winner;
`ifdef ARB_QUANTUM_EN
                    w_nextCnt     = '0;
`endif
                end else begin
                    w_nextState = IDLE;
                    w_nextGrant = '0;
`ifdef ARB_QUANTUM_EN
                    w_nextCnt   = '0;
`endif
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextGrant = '0;
            end
        endcase
    end

    // Reset parks last on the highest master so master 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_grantId <= '0;
            r_last    <= ID_W'(NUM_M - 1);
        end else begin
            r_state   <= w_nextState;
            r_grant   <= w_nextGrant;
            r_grantId <= w_nextGrantId;
            r_last    <= w_nextLast;
        end
    end

`ifdef ARB_QUANTUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nextCnt;
        end
    end
`endif

    assign grant       = r_grant;
    assign grant_id    = r_grantId;
    assign grant_valid = |r_grant;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr with NUM_M=4, QUANTUM=4.
// Expectations for the quantum scenario follow ARB_QUANTUM_EN when it is defined.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grantId;
    logic       grantValid;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_M  (4),
        .ID_W   (2),
        .QUANTUM(4),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .grant      (grant),
        .grant_id   (grantId),
        .grant_valid(grantValid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset across one full clock period, releasing at a falling edge with req applied.
    task automatic doReset(input logic [3:0] r);
        @(negedge clk);
        reset_n = 1'b0;
        req     = r;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        #3;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_grant: got %b expected %b", grant, 4'b0000);
        end
        checks++;
        if (grantId !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_id: got %0d expected %0d", grantId, 0);
        end
        checks++;
        if (grantValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected %b", grantValid, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || grantValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got %b/%b expected 0001/1", grant, grantValid);
        end
    endtask

    task automatic test_hold();
        doReset(4'b0001);
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (grant !== 4'b0001 || grantId !== 2'd0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got %b id %0d expected 0001 id 0", c, grant, grantId);
            end
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (grant !== 4'b0000 || grantValid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_release%0d: got %b/%b expected 0000/0", c, grant, grantValid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expGrant;
        doReset(4'b1111);
        for (int i = 0; i < 4; i++) begin
            expGrant = 4'b0001 << i;
            for (int c = 0; c < 2; c++) begin
                step();
                checks++;
                if (grant !== expGrant || grantId !== 2'(i)) begin
                    errors++;
                    $display("[TB] FAIL b2b_owner%0d_cycle%0d: got %b id %0d expected %b id %0d",
                             i, c, grant, grantId, expGrant, i);
                end
            end
            req[i] = 1'b0;
        end
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL b2b_end: got %b expected 0000", grant);
        end
    endtask

    task automatic test_rr_order();
        doReset(4'b0100);
        step();
        checks++;
        if (grant !== 4'b0100 || grantId !== 2'd2) begin
            errors++;
            $display("[TB] FAIL rr_owner2: got %b id %0d expected 0100 id 2", grant, grantId);
        end
        req = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b1000 || grantId !== 2'd3) begin
            errors++;
            $display("[TB] FAIL rr_handover: got %b id %0d expected 1000 id 3", grant, grantId);
        end
        doReset(4'b0110);
        step();
        checks++;
        if (grant !== 4'b0010 || grantId !== 2'd1) begin
            errors++;
            $display("[TB] FAIL rr_simultaneous: got %b id %0d expected 0010 id 1", grant, grantId);
        end
    endtask

    task automatic test_quantum();
        logic [3:0] expGrant;
        doReset(4'b0011);
        for (int c = 0; c < 12; c++) begin
            step();
`ifdef ARB_QUANTUM_EN
            expGrant = (((c / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
            expGrant = 4'b0001;
`endif
            checks++;
            if (grant !== expGrant) begin
                errors++;
                $display("[TB] FAIL quantum_pair_cycle%0d: got %b expected %b", c, grant, expGrant);
            end
        end
        doReset(4'b0001);
        for (int c = 0; c < 9; c++) begin
            step();
            checks++;
            if (grant !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL quantum_alone_cycle%0d: got %b expected 0001", c, grant);
            end
        end
    endtask

    task automatic test_reset_mid();
        doReset(4'b0100);
        step();
        step();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL mid_pre: got %b expected 0100", grant);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || grantValid !== 1'b0 || grantId !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_async_clear: got %b/%b id %0d expected 0000/0 id 0",
                     grant, grantValid, grantId);
        end
        req = 4'b1010;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0010 || grantId !== 2'd1) begin
            errors++;
            $display("[TB] FAIL mid_restart: got %b id %0d expected 0010 id 1", grant, grantId);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_back_to_back();
        test_rr_order();
        test_quantum();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
